// File: rtl/neo_pkg.sv
// -----------------------------------------------------------------------------
// neo_pkg
// Shared definitions for the NEO (nonlinear energy operator) read-side
// sequencer and its datapath core.
//   neo_seq_state_t : sequencer FSM states
//   RD_LATENCY      : sample memory read latency in cycles (registered read)
//   PIPE_DEPTH      : cycles from the last read address to the last result
//                     write (capture, window, output register)
//   sat_n()         : arithmetic right shift followed by saturation to n bits
// -----------------------------------------------------------------------------
package neo_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } neo_seq_state_t;

    localparam int RD_LATENCY = 1;
    localparam int PIPE_DEPTH = 3;

    // Shift then clamp to the signed n-bit range. The 64-bit container covers
    // a 2N+1-bit psi for any N up to 31; callers keep the low n bits.
    function automatic logic signed [63:0] sat_n(input logic signed [63:0] v,
                                                 input int                 shift,
                                                 input int                 n);
        logic signed [63:0] s;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        s  = v >>> shift;
        hi = (64'sd1 <<< (n - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (n - 1));
        if (s > hi) begin
            return hi;
        end
        if (s < lo) begin
            return lo;
        end
        return s;
    endfunction

endpackage

// File: rtl/neo_core.sv
// -----------------------------------------------------------------------------
// neo_core
// Three-sample window and psi datapath of the NEO sequencer.
// Each valid input sample shifts into the window {x0, x1, x2}; once three
// valid samples are held, psi = x1*x1 - x0*x2 is shifted, saturated and
// registered onto the result write port.
// Ports:
//   Clk       in   rising-edge clock
//   reset     in   asynchronous active-high reset
//   clear     in   frame start: drops the window valid bits
//   in_valid  in   in_data carries a new sample this cycle
//   in_data   in   signed sample from the memory
//   fire      out  a psi is computed this cycle (registered out next edge)
//   clip      out  the psi computed this cycle saturates
//   wen       out  registered write strobe
//   wdata     out  registered saturated psi (holds when wen=0)
// -----------------------------------------------------------------------------
module neo_core
    import neo_pkg::*;
#(
    parameter int N     = 16,
    parameter int SHIFT = 0
) (
    input  logic                Clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                in_valid,
    input  logic signed [N-1:0] in_data,
    output logic                fire,
    output logic                clip,
    output logic                wen,
    output logic signed [N-1:0] wdata
);

    logic signed [N-1:0]   x0;
    logic signed [N-1:0]   x1;
    logic signed [N-1:0]   x2;
    logic [2:0]            vld;       // vld[0] rides with x2, vld[2] with x0
    logic                  win_new;   // window shifted on the last edge

    logic signed [2*N-1:0] p11;
    logic signed [2*N-1:0] p02;
    logic signed [2*N:0]   psi;
    logic signed [2*N:0]   psi_sh;
    logic signed [N-1:0]   psi_sat;

    // Operands are widened first so the products are full precision.
    assign p11     = (2*N)'(x1) * (2*N)'(x1);
    assign p02     = (2*N)'(x0) * (2*N)'(x2);
    assign psi     = (2*N+1)'(p11) - (2*N+1)'(p02);
    assign psi_sh  = psi >>> SHIFT;
    assign psi_sat = N'(sat_n(64'(psi), SHIFT, N));

    // Each window position is evaluated once: only right after a shift.
    assign fire = win_new & (&vld);
    assign clip = (2*N+1)'(psi_sat) != psi_sh;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values and the window shifts as a true pipeline.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            // NOTE: the window data is reset along with its valid bits so an
            // aborted frame leaves nothing behind that could reach wdata.
            x0      <= '0;
            x1      <= '0;
            x2      <= '0;
            vld     <= '0;
            win_new <= 1'b0;
            wen     <= 1'b0;
            wdata   <= '0;
        end else begin
            wen <= fire;
            if (fire) begin
                wdata <= psi_sat;
            end
            if (clear) begin
                vld     <= '0;
                win_new <= 1'b0;
            end else begin
                win_new <= in_valid;
                if (in_valid) begin
                    x0  <= x1;
                    x1  <= x2;
                    x2  <= in_data;
                    vld <= {vld[1:0], 1'b1};
                end
            end
        end
    end

endmodule

// File: rtl/neo_mem_sequencer.sv
// -----------------------------------------------------------------------------
// neo_mem_sequencer
// Read-side initiator for the NEO sample memory. On start it reads addresses
// 0..M-1, feeds the returned samples through neo_core and writes
// psi[n] = x[n]^2 - x[n-1]*x[n+1] for n = 1..M-2 to the result store.
// Ports:
//   Clk       in   rising-edge clock
//   reset     in   asynchronous active-high reset
//   start     in   1-cycle pulse, accepted only when idle
//   rdata     in   signed sample, valid one cycle after raddr/ren
//   raddr     out  sample read address
//   ren       out  read address valid
//   waddr     out  result write address (centre index n)
//   wdata     out  saturated psi[n]
//   wen       out  result write strobe
//   busy      out  high from start acceptance through the done cycle
//   done      out  1-cycle end-of-frame pulse
//   sat_flag  out  sticky per frame: some psi saturated
// All outputs are registered.
// -----------------------------------------------------------------------------
module neo_mem_sequencer
    import neo_pkg::*;
#(
    parameter int N     = 16,
    parameter int M     = 32,
    parameter int SHIFT = 0,
    localparam int AW   = $clog2(M)
) (
    input  logic                Clk,
    input  logic                reset,
    input  logic                start,
    input  logic signed [N-1:0] rdata,
    output logic [AW-1:0]       raddr,
    output logic                ren,
    output logic [AW-1:0]       waddr,
    output logic signed [N-1:0] wdata,
    output logic                wen,
    output logic                busy,
    output logic                done,
    output logic                sat_flag
);

    neo_seq_state_t        state;
    logic [RD_LATENCY-1:0] ren_pipe;   // ren delayed to line up with rdata
    logic [1:0]            dcnt;       // DRAIN cycle counter
    logic [AW-1:0]         wcnt;       // centre index of the next result
    logic                  accept;
    logic                  core_fire;
    logic                  core_clip;

    assign accept = (state == IDLE) && start;

    neo_core #(
        .N     (N),
        .SHIFT (SHIFT)
    ) u_core (
        .Clk      (Clk),
        .reset    (reset),
        .clear    (accept),
        .in_valid (ren_pipe[RD_LATENCY-1]),
        .in_data  (rdata),
        .fire     (core_fire),
        .clip     (core_clip),
        .wen      (wen),
        .wdata    (wdata)
    );

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            raddr    <= '0;
            ren      <= 1'b0;
            ren_pipe <= '0;
            dcnt     <= '0;
            wcnt     <= '0;
            waddr    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sat_flag <= 1'b0;
        end else begin
            ren_pipe <= RD_LATENCY'({ren_pipe, ren});

            // waddr is registered on the same edge the core registers wen.
            if (core_fire) begin
                waddr <= wcnt;
                wcnt  <= wcnt + AW'(1);
                if (core_clip) begin
                    sat_flag <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= READ;
                        raddr    <= '0;
                        ren      <= 1'b1;
                        busy     <= 1'b1;
                        sat_flag <= 1'b0;
                        wcnt     <= AW'(1);
                        dcnt     <= '0;
                    end
                end
                READ: begin
                    // Stop at the last address instead of wrapping.
                    if (raddr == AW'(M - 1)) begin
                        state <= DRAIN;
                        raddr <= '0;
                        ren   <= 1'b0;
                    end else begin
                        raddr <= raddr + AW'(1);
                    end
                end
                DRAIN: begin
                    // Wait for the last sample to clear the pipeline.
                    if (dcnt == 2'(PIPE_DEPTH - 1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                        dcnt  <= '0;
                    end else begin
                        dcnt <= dcnt + 2'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neo_mem_sequencer.sv
// -----------------------------------------------------------------------------
// tb_neo_mem_sequencer
// Scoreboard bench for neo_mem_sequencer. Each accepted start pushes the
// expected result writes (address, value, cycle) and the expected done cycle
// and sat_flag, computed directly from the memory contents with integer
// arithmetic. A monitor on the falling edge pops and compares whenever the
// DUT writes or signals done, and checks ren/raddr/busy against the frame
// timeline every cycle.
// -----------------------------------------------------------------------------
module tb_neo_mem_sequencer;

    localparam int N     = 16;
    localparam int M     = 32;
    localparam int SHIFT = 0;
    localparam int AW    = $clog2(M);

    logic                Clk;
    logic                reset;
    logic                start;
    logic signed [N-1:0] rdata;
    logic [AW-1:0]       raddr;
    logic                ren;
    logic [AW-1:0]       waddr;
    logic signed [N-1:0] wdata;
    logic                wen;
    logic                busy;
    logic                done;
    logic                sat_flag;

    neo_mem_sequencer #(
        .N     (N),
        .M     (M),
        .SHIFT (SHIFT)
    ) dut (
        .Clk      (Clk),
        .reset    (reset),
        .start    (start),
        .rdata    (rdata),
        .raddr    (raddr),
        .ren      (ren),
        .waddr    (waddr),
        .wdata    (wdata),
        .wen      (wen),
        .busy     (busy),
        .done     (done),
        .sat_flag (sat_flag)
    );

    typedef struct {
        int addr;
        int data;
        int cyc;
    } wr_t;

    wr_t                 exp_q[$];
    int                  done_q[$];
    bit                  sat_q[$];
    logic signed [N-1:0] mem [M];

    int n_checks     = 0;
    int n_errors     = 0;
    int cyc          = 0;
    int frame_c      = 0;
    bit frame_active = 0;
    int first_wdata  = 0;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc++;

    // Sample memory: registered read, one cycle latency.
    always @(posedge Clk) begin
        if (ren) rdata <= mem[raddr];
    end

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Reference: psi from the definition, shifted and clamped to N bits.
    function automatic int ref_psi(input int n, output bit clipped);
        longint a, b, c, p;
        longint hi, lo;
        a  = longint'(mem[n-1]);
        b  = longint'(mem[n]);
        c  = longint'(mem[n+1]);
        p  = (b * b - a * c) >>> SHIFT;
        hi = (64'sd1 <<< (N - 1)) - 1;
        lo = -(64'sd1 <<< (N - 1));
        clipped = 1'b0;
        if (p > hi) begin clipped = 1'b1; p = hi; end
        if (p < lo) begin clipped = 1'b1; p = lo; end
        return int'(p);
    endfunction

    task automatic push_frame(input int c);
        bit any_clip;
        bit cl;
        int v;
        any_clip = 1'b0;
        for (int n = 1; n <= M - 2; n++) begin
            v = ref_psi(n, cl);
            any_clip |= cl;
            exp_q.push_back('{n, v, c + n + 4});
        end
        done_q.push_back(c + M + 3);
        sat_q.push_back(any_clip);
    endtask

    // Monitor / scoreboard side.
    always @(negedge Clk) begin : monitor
        int  k;
        bit  e_ren;
        bit  e_busy;
        wr_t e;
        if (!reset) begin
            k      = cyc - frame_c;
            e_ren  = frame_active && k >= 0 && k < M;
            e_busy = frame_active && k >= 0 && k <= M + 3;
            check("ren", ren, e_ren);
            check("raddr", raddr, e_ren ? k : 0);
            check("busy", busy, e_busy);
            if (wen) begin
                if (exp_q.size() == 0) begin
                    check("wen_unexpected", wen, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("waddr", waddr, e.addr);
                    check("wdata", wdata, e.data);
                    check("wen_cycle", cyc, e.cyc);
                    if (e.addr == 1) first_wdata = int'(wdata);
                end
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    check("done_unexpected", done, 0);
                end else begin
                    check("done_cycle", cyc, done_q.pop_front());
                    check("sat_flag", sat_flag, sat_q.pop_front());
                    check("writes_left_at_done", exp_q.size(), 0);
                end
            end
        end
    end

    // Stimulus side.
    task automatic do_start();
        @(negedge Clk);
        start        = 1'b1;
        frame_c      = cyc + 1;
        push_frame(frame_c);
        frame_active = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        check("sat_flag_cleared_on_start", sat_flag, 0);
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 3 * M && !seen; i++) begin
            @(negedge Clk);
            seen = done;
        end
        if (!seen) check("done_timeout", done, 1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_raddr"}, raddr, 0);
        check({tag, "_ren"}, ren, 0);
        check({tag, "_waddr"}, waddr, 0);
        check({tag, "_wdata"}, wdata, 0);
        check({tag, "_wen"}, wen, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_sat_flag"}, sat_flag, 0);
    endtask

    task automatic fill_random(input bit wide);
        int v;
        for (int k = 0; k < M; k++) begin
            v      = wide ? int'($urandom) : int'($urandom_range(0, 400)) - 200;
            mem[k] = N'(v);
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        rdata = '0;
        for (int k = 0; k < M; k++) mem[k] = '0;
        repeat (3) @(negedge Clk);
        check_outputs_zero("reset");
        reset = 1'b0;
        repeat (2) @(negedge Clk);

        // Ramp: every psi is 1.
        for (int k = 0; k < M; k++) mem[k] = N'(k);
        do_start();
        wait_done();
        repeat (2) @(negedge Clk);

        // Constant: every psi is 0, no saturation.
        for (int k = 0; k < M; k++) mem[k] = N'(100);
        do_start();
        wait_done();
        repeat (2) @(negedge Clk);

        // Alternating 100/0: psi[1] = 0 - 100*100.
        for (int k = 0; k < M; k++) mem[k] = (k % 2 == 0) ? N'(100) : N'(0);
        do_start();
        wait_done();
        check("alt_psi1", first_wdata, -10000);
        repeat (2) @(negedge Clk);

        // Alternating 0/1000: psi[1] = 10^6 saturates high, sat_flag set.
        for (int k = 0; k < M; k++) mem[k] = (k % 2 == 1) ? N'(1000) : N'(0);
        do_start();
        wait_done();
        check("sat_psi1", first_wdata, 32767);
        check("sat_flag_after_clip", sat_flag, 1);
        repeat (2) @(negedge Clk);

        // Start during READ and on the done cycle are ignored; start on the
        // cycle after done is accepted (do_start keeps start high into it).
        fill_random(1'b0);
        do_start();
        repeat (5) @(negedge Clk);
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        wait_done();
        start = 1'b1;
        fill_random(1'b1);
        do_start();
        wait_done();
        repeat (2) @(negedge Clk);

        // Reset in the middle of a frame.
        fill_random(1'b1);
        do_start();
        for (int i = 0; i < 20 && cyc != frame_c + 10; i++) @(posedge Clk);
        #2;
        reset = 1'b1;
        #1;
        check_outputs_zero("abort");
        exp_q.delete();
        done_q.delete();
        sat_q.delete();
        frame_active = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        reset = 1'b0;
        repeat (M + 10) @(negedge Clk);
        fill_random(1'b0);
        do_start();
        wait_done();
        repeat (2) @(negedge Clk);

        // Randomized frames, mixing narrow and full-range samples.
        for (int f = 0; f < 6; f++) begin
            fill_random(f[0]);
            do_start();
            wait_done();
            repeat ($urandom_range(1, 3)) @(negedge Clk);
        end

        repeat (3) @(negedge Clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
